// File: rtl/seven_seg_letter_decoder.sv
// Registered letter-code to 7-segment glyph decoder for word-guess displays.
// Ports: clk, rst (sync, active-low), code[4:0], blank -> seg[6:0] {g..a}, valid.
module seven_seg_letter_decoder #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] code,
  input  logic       blank,
  output logic [6:0] seg,
  output logic       valid
);

  localparam logic [6:0] GLYPH_OFF = 7'h7F;
  localparam logic [6:0] SEG_OFF =
    SEG_ACTIVE_LOW ? GLYPH_OFF : ~GLYPH_OFF;

  logic [6:0] w_glyph;
  logic       w_legal;
  logic [6:0] w_seg_al;
  logic [6:0] w_seg;
  logic       w_valid;

  logic [6:0] r_seg;
  logic       r_valid;

  // Table is held active-low; polarity is applied afterwards.
  always_comb begin
    w_glyph = GLYPH_OFF;
    w_legal = 1'b1;
    unique case (code)
      5'd1:    w_glyph = 7'h08;
      5'd2:    w_glyph = 7'h03;
      5'd3:    w_glyph = 7'h46;
      5'd4:    w_glyph = 7'h21;
      5'd5:    w_glyph = 7'h06;
      5'd6:    w_glyph = 7'h0E;
      5'd7:    w_glyph = 7'h42;
      5'd8:    w_glyph = 7'h09;
      5'd9:    w_glyph = 7'h4F;
      5'd10:   w_glyph = 7'h61;
      5'd11:   w_glyph = 7'h0A;
      5'd12:   w_glyph = 7'h47;
      5'd13:   w_glyph = 7'h48;
      5'd14:   w_glyph = 7'h2B;
      5'd15:   w_glyph = 7'h40;
      5'd16:   w_glyph = 7'h0C;
      5'd17:   w_glyph = 7'h18;
      5'd18:   w_glyph = 7'h2F;
      5'd19:   w_glyph = 7'h12;
      5'd20:   w_glyph = 7'h07;
      5'd21:   w_glyph = 7'h41;
      5'd22:   w_glyph = 7'h63;
      5'd23:   w_glyph = 7'h55;
      5'd24:   w_glyph = 7'h09;
      5'd25:   w_glyph = 7'h11;
      5'd26:   w_glyph = 7'h24;
      default: begin
        w_glyph = GLYPH_OFF;
        w_legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_valid  = w_legal & ~blank;
    w_seg_al = w_valid ? w_glyph : GLYPH_OFF;
    w_seg    = SEG_ACTIVE_LOW ? w_seg_al : ~w_seg_al;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seg   <= SEG_OFF;
      r_valid <= 1'b0;
    end else begin
      r_seg   <= w_seg;
      r_valid <= w_valid;
    end
  end

  assign seg   = r_seg;
  assign valid = r_valid;

endmodule

// File: tb/tb_seven_seg_letter_decoder.sv
// Bench for seven_seg_letter_decoder: directed scenarios plus random
// stimulus against a table model, both segment polarities in parallel.
module tb_seven_seg_letter_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] code;
  logic       blank;
  logic [6:0] seg_l;
  logic       valid_l;
  logic [6:0] seg_h;
  logic       valid_h;

  int checks = 0;
  int errors = 0;

  logic [6:0] glyphs [0:25];

  always #5 clk = ~clk;

  seven_seg_letter_decoder #(.SEG_ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst(rst), .code(code), .blank(blank),
    .seg(seg_l), .valid(valid_l)
  );

  seven_seg_letter_decoder #(.SEG_ACTIVE_LOW(1'b0)) u_ah (
    .clk(clk), .rst(rst), .code(code), .blank(blank),
    .seg(seg_h), .valid(valid_h)
  );

  function automatic logic model_valid(
    input logic [4:0] c, input logic b);
    return (!b) && (c >= 1) && (c <= 26);
  endfunction

  function automatic logic [6:0] model_seg(
    input logic [4:0] c, input logic b, input logic al);
    logic [6:0] g;
    g = model_valid(c, b) ? glyphs[int'(c) - 1] : 7'h7F;
    return al ? g : ~g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; code = 5'd1; blank = 1'b0;
    tick();
    tick();
    checks++;
    if (seg_l !== 7'h7F || valid_l !== 1'b0) begin
      errors++;
      $display("FAIL reset_al seg=%h valid=%b want 7f 0", seg_l, valid_l);
    end
    checks++;
    if (seg_h !== 7'h00 || valid_h !== 1'b0) begin
      errors++;
      $display("FAIL reset_ah seg=%h valid=%b want 00 0", seg_h, valid_h);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (seg_l !== 7'h08 || valid_l !== 1'b1) begin
      errors++;
      $display("FAIL reset_release seg=%h valid=%b want 08 1",
               seg_l, valid_l);
    end
  endtask

  task automatic test_sweep();
    blank = 1'b0;
    for (int c = 0; c < 32; c++) begin
      code = 5'(c);
      tick();
      checks++;
      if (seg_l !== model_seg(5'(c), 1'b0, 1'b1) ||
          valid_l !== model_valid(5'(c), 1'b0)) begin
        errors++;
        $display("FAIL sweep code=%0d seg=%h valid=%b want %h %b", c,
                 seg_l, valid_l, model_seg(5'(c), 1'b0, 1'b1),
                 model_valid(5'(c), 1'b0));
      end
    end
  endtask

  task automatic test_blank();
    code = 5'd15; blank = 1'b1;
    tick();
    checks++;
    if (seg_l !== 7'h7F || valid_l !== 1'b0) begin
      errors++;
      $display("FAIL blank_on seg=%h valid=%b want 7f 0", seg_l, valid_l);
    end
    blank = 1'b0;
    tick();
    checks++;
    if (seg_l !== 7'h40 || valid_l !== 1'b1) begin
      errors++;
      $display("FAIL blank_off seg=%h valid=%b want 40 1", seg_l, valid_l);
    end
  endtask

  task automatic test_illegal();
    blank = 1'b0;
    code = 5'd27;
    tick();
    checks++;
    if (seg_l !== 7'h7F || valid_l !== 1'b0) begin
      errors++;
      $display("FAIL illegal27 seg=%h valid=%b want 7f 0", seg_l, valid_l);
    end
    code = 5'd31;
    tick();
    checks++;
    if (seg_l !== 7'h7F || valid_l !== 1'b0) begin
      errors++;
      $display("FAIL illegal31 seg=%h valid=%b want 7f 0", seg_l, valid_l);
    end
  endtask

  task automatic test_polarity();
    code = 5'd1; blank = 1'b0;
    tick();
    checks++;
    if (seg_h !== 7'h77 || valid_h !== 1'b1) begin
      errors++;
      $display("FAIL polarity_a seg=%h valid=%b want 77 1", seg_h, valid_h);
    end
    code = 5'd0;
    tick();
    checks++;
    if (seg_h !== 7'h00 || valid_h !== 1'b0) begin
      errors++;
      $display("FAIL polarity_blank seg=%h valid=%b want 00 0",
               seg_h, valid_h);
    end
  endtask

  task automatic test_midrun_reset();
    rst = 1'b1; blank = 1'b0; code = 5'd19;
    tick();
    checks++;
    if (seg_l !== 7'h12) begin
      errors++;
      $display("FAIL midrun_pre seg=%h want 12", seg_l);
    end
    rst = 1'b0; code = 5'd26;
    tick();
    checks++;
    if (seg_l !== 7'h7F || valid_l !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst seg=%h valid=%b want 7f 0", seg_l, valid_l);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (seg_l !== 7'h24 || valid_l !== 1'b1) begin
      errors++;
      $display("FAIL midrun_post seg=%h valid=%b want 24 1", seg_l, valid_l);
    end
  endtask

  task automatic test_random();
    logic [4:0] c;
    logic       b;
    logic       r;
    logic [6:0] el;
    logic [6:0] eh;
    logic       ev;
    for (int i = 0; i < 400; i++) begin
      c = 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 15) != 0);
      code = c; blank = b; rst = r;
      tick();
      el = r ? model_seg(c, b, 1'b1) : 7'h7F;
      eh = r ? model_seg(c, b, 1'b0) : 7'h00;
      ev = r ? model_valid(c, b) : 1'b0;
      checks++;
      if (seg_l !== el || valid_l !== ev ||
          seg_h !== eh || valid_h !== ev) begin
        errors++;
        $display("FAIL random c=%0d b=%b r=%b got %h/%h/%b/%b want %h/%h/%b",
                 c, b, r, seg_l, seg_h, valid_l, valid_h, el, eh, ev);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    glyphs = '{7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h42,
               7'h09, 7'h4F, 7'h61, 7'h0A, 7'h47, 7'h48, 7'h2B,
               7'h40, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07, 7'h41,
               7'h63, 7'h55, 7'h09, 7'h11, 7'h24};
    rst = 1'b0; code = 5'd0; blank = 1'b0;
    test_reset();
    test_sweep();
    test_blank();
    test_illegal();
    test_polarity();
    test_midrun_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
